pulse_debouncer: RTL and testbench

Conditions a raw, asynchronous push-button input into a clean single-cycle enable pulse for the 4-bit counter stage, which sits directly downstream and consumes `en_pulse` as its count enable. The block synchronizes the input, debounces press and release with a parameterized stability window, and emits exactly one pulse per debounced press. An optional auto-repeat mode emits further pulses while the button is held.

---
 rtl/pulse_debouncer.sv | 162 ++++++++++++++++
 tb/tb_pulse_debouncer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_debouncer.sv
// Push-button conditioner: two-flop synchronizer, press/release debounce FSM and
// optional auto-repeat, producing a registered single-cycle count-enable pulse.
module pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic en_pulse,
    output logic btn_level
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_DLY_V = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER_V = REP_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic             r_s1;
    logic             r_btn_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [REP_W-1:0] r_rep_tmr;
    logic             r_rep_first;
    logic             r_en_pulse;
    logic             r_btn_level;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [REP_W-1:0] w_rep_nxt;
    logic [REP_W-1:0] w_rep_inc;
    logic             w_rep_first_nxt;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
    logic             w_rep_hit;

    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_rep_inc = r_rep_tmr + REP_W'(1);
    // The first repeat waits the full delay; later ones use the shorter period.
    assign w_rep_hit = r_rep_first ? (w_rep_inc == REP_PER_V) : (w_rep_inc == REP_DLY_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_s1       <= btn_in;
            r_btn_sync <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rep_tmr   <= '0;
            r_rep_first <= 1'b0;
            r_en_pulse  <= 1'b0;
            r_btn_level <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rep_tmr   <= w_rep_nxt;
            r_rep_first <= w_rep_first_nxt;
            r_en_pulse  <= w_pulse_nxt;
            r_btn_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rep_nxt       = r_rep_tmr;
        w_rep_first_nxt = r_rep_first;
        w_pulse_nxt     = 1'b0;
        w_level_nxt     = r_btn_level;

        case (r_state)
            IDLE: begin
                w_level_nxt = 1'b0;
                w_cnt_nxt   = '0;
                if (r_btn_sync) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!r_btn_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = HELD;
                    w_cnt_nxt       = '0;
                    w_pulse_nxt     = 1'b1;
                    w_level_nxt     = 1'b1;
                    w_rep_nxt       = '0;
                    w_rep_first_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            HELD: begin
                if (!r_btn_sync) begin
                    w_state_nxt     = RELEASE_WAIT;
                    w_cnt_nxt       = CNT_ONE;
                    w_rep_nxt       = '0;
                    w_rep_first_nxt = 1'b0;
                end else if (REPEAT_EN != 0) begin
                    if (w_rep_hit) begin
                        w_pulse_nxt     = 1'b1;
                        w_rep_nxt       = '0;
                        w_rep_first_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = w_rep_inc;
                    end
                end
            end

            RELEASE_WAIT: begin
                // A high sample here is release bounce: back to HELD, repeat restarts.
                if (r_btn_sync) begin
                    w_state_nxt     = HELD;
                    w_cnt_nxt       = '0;
                    w_rep_nxt       = '0;
                    w_rep_first_nxt = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign en_pulse  = r_en_pulse;
    assign btn_level = r_btn_level;

endmodule

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer: one instance without repeat, one with
// auto-repeat, plus a model of the downstream 4-bit counter.
module tb_pulse_debouncer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_r;
    logic       en0;
    logic       lvl0;
    logic       en1;
    logic       lvl1;
    logic [3:0] q0;
    int         pcnt0 = 0;
    int         pcnt1 = 0;
    int         n_vec = 0;
    int         n_err = 0;

    pulse_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (0),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn),
        .en_pulse (en0),
        .btn_level(lvl0)
    );

    pulse_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) u_rep (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_r),
        .en_pulse (en1),
        .btn_level(lvl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) q0 <= 4'd0;
        else if (en0) q0 <= q0 + 4'd1;
    end

    always @(posedge clk) begin
        if (en0) pcnt0 <= pcnt0 + 1;
        if (en1) pcnt1 <= pcnt1 + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        int bounce_rel[6];
        int bounce_prs[10];
        logic exp_p;
        bounce_rel = '{0, 1, 0, 0, 0, 0};
        bounce_prs = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

        rst   = 1'b0;
        btn   = 1'b0;
        btn_r = 1'b0;
        #1;
        chk("reset_en", {7'd0, en0}, 8'd0);
        chk("reset_lvl", {7'd0, lvl0}, 8'd0);
        step(3);
        rst = 1'b1;
        step(20);
        chk("idle_pulses", 8'(pcnt0), 8'd0);
        chk("idle_lvl", {7'd0, lvl0}, 8'd0);
        chk("idle_q", {4'd0, q0}, 8'd0);

        // Clean press: pulse only after edge 6
        btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("clean_pre_en", {7'd0, en0}, 8'd0);
        end
        step(1);
        chk("clean_e6_en", {7'd0, en0}, 8'd1);
        chk("clean_e6_lvl", {7'd0, lvl0}, 8'd1);
        step(1);
        chk("clean_e7_en", {7'd0, en0}, 8'd0);
        chk("clean_e7_lvl", {7'd0, lvl0}, 8'd1);
        chk("clean_q", {4'd0, q0}, 8'd1);
        step(10);
        chk("clean_hold_q", {4'd0, q0}, 8'd1);

        // Release with a one-cycle glitch: level falls after edge 8
        for (int i = 0; i < 6; i++) begin
            btn = bounce_rel[i][0];
            step(1);
            chk("rel_glitch_lvl", {7'd0, lvl0}, 8'd1);
            chk("rel_glitch_en", {7'd0, en0}, 8'd0);
        end
        step(1);
        chk("rel_e7_lvl", {7'd0, lvl0}, 8'd1);
        step(1);
        chk("rel_e8_lvl", {7'd0, lvl0}, 8'd0);
        chk("rel_q", {4'd0, q0}, 8'd1);
        step(5);
        btn = 1'b1;
        step(6);
        chk("press2_en", {7'd0, en0}, 8'd1);
        step(1);
        chk("press2_q", {4'd0, q0}, 8'd2);
        btn = 1'b0;
        step(10);
        chk("press2_rel_lvl", {7'd0, lvl0}, 8'd0);

        // Bouncy press: final high run starts at edge 6, pulse after edge 11
        for (int i = 0; i < 10; i++) begin
            btn = bounce_prs[i][0];
            step(1);
            chk("bouncy_pre_en", {7'd0, en0}, 8'd0);
        end
        step(1);
        chk("bouncy_e11_en", {7'd0, en0}, 8'd1);
        step(1);
        chk("bouncy_e12_en", {7'd0, en0}, 8'd0);
        chk("bouncy_q", {4'd0, q0}, 8'd3);
        btn = 1'b0;
        step(10);
        chk("bouncy_rel_lvl", {7'd0, lvl0}, 8'd0);

        // Auto-repeat: P=6, repeats at 16,21,...,41; release before a P+40 repeat
        btn_r = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            exp_p = (k == 6) || (k >= 16 && k <= 41 && ((k - 16) % 5) == 0);
            chk("repeat_en", {7'd0, en1}, {7'd0, exp_p});
            if (k == 43) btn_r = 1'b0;
        end
        chk("repeat_count", 8'(pcnt1), 8'd7);
        chk("repeat_rel_lvl", {7'd0, lvl1}, 8'd0);

        // Reset mid-debounce with the button still held
        btn = 1'b1;
        step(4);
        rst = 1'b0;
        #1;
        chk("middeb_en", {7'd0, en0}, 8'd0);
        chk("middeb_lvl", {7'd0, lvl0}, 8'd0);
        step(2);
        #2;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("postrst_pre_en", {7'd0, en0}, 8'd0);
        end
        step(1);
        chk("postrst_e6_en", {7'd0, en0}, 8'd1);
        chk("postrst_e6_lvl", {7'd0, lvl0}, 8'd1);

        // Asynchronous reset mid-cycle while the pulse is high
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_en", {7'd0, en0}, 8'd0);
        chk("async_rst_lvl", {7'd0, lvl0}, 8'd0);
        rst = 1'b1;
        btn = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
